regfile_arbiter: RTL and testbench

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

---
 rtl/regfile_arbiter_if.sv | 42 ++++
 rtl/regfile_arbiter.sv | 123 ++++++++++++
 tb/tb_regfile_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_arbiter_if.sv
// rtl/regfile_arbiter_if.sv - requester A/B command, grant/done and register file port bundle.
// ERR is present only when REGFILE_ARB_READBACK_EN is defined.
interface regfile_arbiter_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2
);
  logic              A_REQ, B_REQ;
  logic              A_WE, B_WE;
  logic [ADDR_W-1:0] A_RS, A_RT, A_RW;
  logic [ADDR_W-1:0] B_RS, B_RT, B_RW;
  logic [DATA_W-1:0] A_DW, B_DW;
  logic              A_GNT, B_GNT;
  logic              A_DONE, B_DONE;
  logic [DATA_W-1:0] A_CRS, A_CRT, B_CRS, B_CRT;
  logic [ADDR_W-1:0] RS, RT, RW;
  logic [DATA_W-1:0] DW;
  logic              RG_WE;
  logic [DATA_W-1:0] CRS, CRT;
`ifdef REGFILE_ARB_READBACK_EN
  logic              ERR;
`endif

  modport slave (
    input  A_REQ, B_REQ, A_WE, B_WE, A_RS, A_RT, A_RW, B_RS, B_RT, B_RW,
           A_DW, B_DW, CRS, CRT,
    output A_GNT, B_GNT, A_DONE, B_DONE, A_CRS, A_CRT, B_CRS, B_CRT,
           RS, RT, RW, DW, RG_WE
`ifdef REGFILE_ARB_READBACK_EN
    , output ERR
`endif
  );

  modport master (
    output A_REQ, B_REQ, A_WE, B_WE, A_RS, A_RT, A_RW, B_RS, B_RT, B_RW,
           A_DW, B_DW, CRS, CRT,
    input  A_GNT, B_GNT, A_DONE, B_DONE, A_CRS, A_CRT, B_CRS, B_CRT,
           RS, RT, RW, DW, RG_WE
`ifdef REGFILE_ARB_READBACK_EN
    , input ERR
`endif
  );
endinterface

// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - round-robin two-requester arbiter in front of a register file port.
// Define REGFILE_ARB_READBACK_EN to verify every write with a readback cycle and a sticky ERR flag.
module regfile_arbiter #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2
) (
  input logic               CLK,
  input logic               RST,
  regfile_arbiter_if.slave  bus
);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SERVE    = 2'd1;
`ifdef REGFILE_ARB_READBACK_EN
  localparam logic [1:0] READBACK = 2'd2;
`endif

  logic [1:0]        state;
  logic              ptr_b;
  logic              win_b;
  logic              pick_b;
  logic              we_q;
  logic [ADDR_W-1:0] rs_q, rt_q, rw_q;
  logic [DATA_W-1:0] dw_q;
  logic              a_done_q, b_done_q;
  logic [DATA_W-1:0] a_crs_q, a_crt_q, b_crs_q, b_crt_q;
  logic              finish;
  logic              in_serve;
  logic              in_readback;
  logic [DATA_W-1:0] ret_rs, ret_rt;

  // B wins only when A is idle or when A was the last one served.
  assign pick_b   = bus.B_REQ & (~bus.A_REQ | ptr_b);
  assign in_serve = (state == SERVE);

`ifdef REGFILE_ARB_READBACK_EN
  logic err_q;
  assign in_readback = (state == READBACK);
  assign finish      = (in_serve & ~we_q) | in_readback;
`else
  assign in_readback = 1'b0;
  assign finish      = in_serve;
`endif

  // Writes report zero read data; reads return the register file outputs.
  assign ret_rs = we_q ? '0 : bus.CRS;
  assign ret_rt = we_q ? '0 : bus.CRT;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      ptr_b    <= 1'b0;
      win_b    <= 1'b0;
      we_q     <= 1'b0;
      rs_q     <= '0;
      rt_q     <= '0;
      rw_q     <= '0;
      dw_q     <= '0;
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
      a_crs_q  <= '0;
      a_crt_q  <= '0;
      b_crs_q  <= '0;
      b_crt_q  <= '0;
`ifdef REGFILE_ARB_READBACK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      a_done_q <= finish & ~win_b;
      b_done_q <= finish & win_b;
      if (finish) begin
        if (win_b) begin
          b_crs_q <= ret_rs;
          b_crt_q <= ret_rt;
        end else begin
          a_crs_q <= ret_rs;
          a_crt_q <= ret_rt;
        end
      end
      case (state)
        IDLE: begin
          if (bus.A_REQ | bus.B_REQ) begin
            state <= SERVE;
            win_b <= pick_b;
            ptr_b <= ~pick_b;
            we_q  <= pick_b ? bus.B_WE : bus.A_WE;
            rs_q  <= pick_b ? bus.B_RS : bus.A_RS;
            rt_q  <= pick_b ? bus.B_RT : bus.A_RT;
            rw_q  <= pick_b ? bus.B_RW : bus.A_RW;
            dw_q  <= pick_b ? bus.B_DW : bus.A_DW;
          end
        end
`ifdef REGFILE_ARB_READBACK_EN
        SERVE:    state <= we_q ? READBACK : IDLE;
        READBACK: begin
          state <= IDLE;
          if (bus.CRS != dw_q) err_q <= 1'b1;
        end
`else
        SERVE:    state <= IDLE;
`endif
        default:  state <= IDLE;
      endcase
    end
  end

  // Every output is forced low while reset is asserted, aborting any write in flight.
  assign bus.A_GNT  = ~RST & in_serve & ~win_b;
  assign bus.B_GNT  = ~RST & in_serve & win_b;
  assign bus.RG_WE  = ~RST & in_serve & we_q;
  assign bus.A_DONE = ~RST & a_done_q;
  assign bus.B_DONE = ~RST & b_done_q;
  assign bus.RS     = RST ? '0 : (in_readback ? rw_q : rs_q);
  assign bus.RT     = RST ? '0 : rt_q;
  assign bus.RW     = RST ? '0 : rw_q;
  assign bus.DW     = RST ? '0 : dw_q;
  assign bus.A_CRS  = RST ? '0 : a_crs_q;
  assign bus.A_CRT  = RST ? '0 : a_crt_q;
  assign bus.B_CRS  = RST ? '0 : b_crs_q;
  assign bus.B_CRT  = RST ? '0 : b_crt_q;
`ifdef REGFILE_ARB_READBACK_EN
  assign bus.ERR    = ~RST & err_q;
`endif
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - scoreboard bench for regfile_arbiter with a behavioural register file.
// Honours REGFILE_ARB_READBACK_EN for write latency and the ERR flag.
module tb_regfile_arbiter;
`ifdef REGFILE_ARB_READBACK_EN
  localparam int WLAT = 2;
`else
  localparam int WLAT = 1;
`endif

  typedef struct { bit who; bit we; logic [1:0] addr; logic [3:0] dw; } gnt_t;
  typedef struct { logic [3:0] crs; logic [3:0] crt; int lat; } done_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic corrupt = 1'b0;
  logic [3:0] mem [4] = '{default: 4'h0};
  int cyc = 0;
  int checks = 0;
  int fails = 0;
  int last_gnt [2] = '{0, 0};
  gnt_t  gq [$];
  done_t exp_a [$];
  done_t exp_b [$];

  regfile_arbiter_if #(.DATA_W(4), .ADDR_W(2)) bus ();

  regfile_arbiter #(.DATA_W(4), .ADDR_W(2)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (bus.RG_WE) mem[bus.RW] <= bus.DW;
  always_comb begin
    bus.CRS = mem[bus.RS] ^ (corrupt ? 4'hF : 4'h0);
    bus.CRT = mem[bus.RT];
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic void push_gnt(bit who, bit we, logic [1:0] addr, logic [3:0] dw);
    gnt_t g;
    g.who = who; g.we = we; g.addr = addr; g.dw = dw;
    gq.push_back(g);
  endfunction

  function automatic void push_done(bit who, logic [3:0] crs, logic [3:0] crt, int lat);
    done_t d;
    d.crs = crs; d.crt = crt; d.lat = lat;
    if (who) exp_b.push_back(d);
    else exp_a.push_back(d);
  endfunction

  task automatic check_done(input bit who);
    done_t d;
    chk(who ? "b_done_expected" : "a_done_expected", who ? exp_b.size() > 0 : exp_a.size() > 0, 1);
    if ((who ? exp_b.size() : exp_a.size()) > 0) begin
      d = who ? exp_b.pop_front() : exp_a.pop_front();
      chk(who ? "b_crs" : "a_crs", who ? bus.B_CRS : bus.A_CRS, d.crs);
      chk(who ? "b_crt" : "a_crt", who ? bus.B_CRT : bus.A_CRT, d.crt);
      chk(who ? "b_done_latency" : "a_done_latency", cyc - last_gnt[who], d.lat);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.A_GNT || bus.B_GNT) begin
        gnt_t g;
        chk("single_grant", bus.A_GNT & bus.B_GNT, 0);
        chk("grant_expected", gq.size() > 0, 1);
        if (gq.size() > 0) begin
          g = gq.pop_front();
          chk("gnt_who", bus.B_GNT, g.who);
          chk("gnt_rg_we", bus.RG_WE, g.we);
          chk("gnt_addr", g.we ? bus.RW : bus.RS, g.addr);
          if (g.we) chk("gnt_dw", bus.DW, g.dw);
        end
        last_gnt[bus.B_GNT] = cyc;
      end else begin
        chk("rg_we_outside_serve", bus.RG_WE, 0);
      end
      chk("single_done", bus.A_DONE & bus.B_DONE, 0);
      if (bus.A_DONE) check_done(1'b0);
      if (bus.B_DONE) check_done(1'b1);
    end
  end

  task automatic do_req(input bit b, input bit we, input logic [1:0] rs, input logic [1:0] rt,
                        input logic [1:0] rw, input logic [3:0] dw);
    bit got = 1'b0;
    @(posedge clk); #1;
    if (b) begin
      bus.B_REQ = 1'b1; bus.B_WE = we; bus.B_RS = rs; bus.B_RT = rt; bus.B_RW = rw; bus.B_DW = dw;
    end else begin
      bus.A_REQ = 1'b1; bus.A_WE = we; bus.A_RS = rs; bus.A_RT = rt; bus.A_RW = rw; bus.A_DW = dw;
    end
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = b ? bus.B_GNT : bus.A_GNT;
    end
    chk(b ? "b_grant_seen" : "a_grant_seen", got, 1);
    @(posedge clk); #1;
    if (b) bus.B_REQ = 1'b0;
    else bus.A_REQ = 1'b0;
  endtask

  task automatic pulse_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int gc [$];
    int dones;
    {bus.A_REQ, bus.B_REQ, bus.A_WE, bus.B_WE} = '0;
    {bus.A_RS, bus.A_RT, bus.A_RW, bus.B_RS, bus.B_RT, bus.B_RW} = '0;
    {bus.A_DW, bus.B_DW} = '0;

    // Reset state, with a write request already pending.
    bus.A_REQ = 1'b1; bus.A_WE = 1'b1; bus.A_RW = 2'd2; bus.A_DW = 4'h9;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_grant_done", {bus.A_GNT, bus.B_GNT, bus.A_DONE, bus.B_DONE}, 0);
    chk("reset_rg_we", bus.RG_WE, 0);
    chk("reset_addr_data", {bus.RS, bus.RT, bus.RW, bus.DW}, 0);
    chk("reset_returns", {bus.A_CRS, bus.A_CRT, bus.B_CRS, bus.B_CRT}, 0);
`ifdef REGFILE_ARB_READBACK_EN
    chk("reset_err", bus.ERR, 0);
`endif
    bus.A_REQ = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // Write then read back through requester A.
    push_gnt(1'b0, 1'b1, 2'd0, 4'h3); push_done(1'b0, 4'h0, 4'h0, WLAT);
    do_req(1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 4'h3);
    push_gnt(1'b0, 1'b0, 2'd0, 4'h0); push_done(1'b0, 4'h3, 4'h3, 1);
    do_req(1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 4'h7);

    // Both requesters held from reset: strict alternation, back-to-back.
    pulse_reset(2);
    for (int i = 0; i < 2; i++) begin
      push_gnt(1'b0, 1'b0, 2'd0, 4'h0); push_gnt(1'b1, 1'b0, 2'd0, 4'h0);
      push_done(1'b0, 4'h3, 4'h3, 1); push_done(1'b1, 4'h3, 4'h0, 1);
    end
    @(posedge clk); #1;
    bus.A_REQ = 1'b1; bus.A_WE = 1'b0; bus.A_RS = 2'd0; bus.A_RT = 2'd0;
    bus.B_REQ = 1'b1; bus.B_WE = 1'b0; bus.B_RS = 2'd0; bus.B_RT = 2'd1;
    for (int i = 0; i < 40 && gc.size() < 4; i++) begin
      @(negedge clk);
      if (bus.A_GNT || bus.B_GNT) gc.push_back(cyc);
    end
    chk("alternation_grants", gc.size(), 4);
    for (int i = 0; i + 1 < gc.size(); i++) chk("alternation_gap", gc[i+1] - gc[i], 2);
    @(posedge clk); #1;
    bus.A_REQ = 1'b0; bus.B_REQ = 1'b0;

    // A served alone leaves the pointer on B, so B's write wins the tie.
    push_gnt(1'b0, 1'b0, 2'd0, 4'h0); push_done(1'b0, 4'h3, 4'h0, 1);
    do_req(1'b0, 1'b0, 2'd0, 2'd1, 2'd0, 4'h0);
    push_gnt(1'b1, 1'b1, 2'd3, 4'hF); push_gnt(1'b0, 1'b0, 2'd3, 4'h0);
    push_done(1'b1, 4'h0, 4'h0, WLAT); push_done(1'b0, 4'hF, 4'hF, 1);
    fork
      do_req(1'b1, 1'b1, 2'd0, 2'd0, 2'd3, 4'hF);
      do_req(1'b0, 1'b0, 2'd3, 2'd3, 2'd0, 4'h0);
    join

    // Reset during a write's SERVE cycle aborts it.
    @(posedge clk); #1;
    bus.A_REQ = 1'b1; bus.A_WE = 1'b1; bus.A_RW = 2'd3; bus.A_DW = 4'h5;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_rg_we", bus.RG_WE, 0);
    chk("abort_grant", bus.A_GNT, 0);
    chk("abort_returns_cleared", bus.A_CRS, 0);
    @(posedge clk); #1;
    rst = 1'b0; bus.A_REQ = 1'b0;
    dones = 0;
    repeat (4) begin
      @(negedge clk);
      dones += int'(bus.A_DONE) + int'(bus.B_DONE);
    end
    chk("abort_no_done", dones, 0);
    push_gnt(1'b0, 1'b0, 2'd3, 4'h0); push_done(1'b0, 4'hF, 4'hF, 1);
    do_req(1'b0, 1'b0, 2'd3, 2'd3, 2'd0, 4'h0);

`ifdef REGFILE_ARB_READBACK_EN
    // Corrupted readback sets ERR, which survives later traffic until reset.
    corrupt = 1'b1;
    push_gnt(1'b0, 1'b1, 2'd1, 4'h6); push_done(1'b0, 4'h0, 4'h0, WLAT);
    do_req(1'b0, 1'b1, 2'd0, 2'd0, 2'd1, 4'h6);
    repeat (2) @(posedge clk);
    #1 corrupt = 1'b0;
    @(negedge clk);
    chk("err_set", bus.ERR, 1);
    push_gnt(1'b0, 1'b0, 2'd1, 4'h0); push_done(1'b0, 4'h6, 4'h3, 1);
    do_req(1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 4'h0);
    repeat (2) @(negedge clk);
    chk("err_sticky", bus.ERR, 1);
    pulse_reset(1);
    @(negedge clk);
    chk("err_cleared", bus.ERR, 0);
`endif

    for (int i = 0; i < 20 && (gq.size() + exp_a.size() + exp_b.size()) > 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", gq.size() + exp_a.size() + exp_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
